// File: rtl/tmr_pkg.sv
// Shared constants and helpers for the TMR stream decoder.
//   DATA_LEN_DEFAULT : default payload width (coded word is 3x this)
//   NUM_REP          : number of replicas in a coded word
//   REP_A/B/C        : replica index into the coded word and the error vector
//   maj3()           : single-bit 2-of-3 majority
package tmr_pkg;

    localparam int unsigned DATA_LEN_DEFAULT = 16;
    localparam int unsigned NUM_REP          = 3;

    localparam int unsigned REP_A = 0;
    localparam int unsigned REP_B = 1;
    localparam int unsigned REP_C = 2;

    // Bitwise 2-of-3 vote; applied per bit so any payload width can use it.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/tmr_err_counter.sv
// Saturating per-replica error counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : add one this cycle (ignored once the counter is full)
//   clr        : synchronous clear, wins over inc
//   cnt        : current count, sticks at all-ones
module tmr_err_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tmr_stream_decoder.sv
// Receive-side TMR decoder: two-stage valid/ready pipeline that majority-votes a
// 3x-replicated word, flags outvoted replicas and counts errors per replica.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake (in_ready is combinational from out_ready)
//   in_data             : {rep_c, rep_b, rep_a}
//   out_valid/out_ready : output handshake
//   out_data            : voted word
//   out_err             : {c,b,a} replica disagreed with the vote
//   out_multi           : two or more replicas disagreed
//   cnt_clr             : synchronous clear of all error counters
//   err_cnt_a/b/c       : saturating per-replica error counts
module tmr_stream_decoder
    import tmr_pkg::*;
#(
    parameter int unsigned DATA_LEN = tmr_pkg::DATA_LEN_DEFAULT,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3*DATA_LEN-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_LEN-1:0]   out_data,
    output logic [NUM_REP-1:0]    out_err,
    output logic                  out_multi,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      err_cnt_a,
    output logic [CNT_W-1:0]      err_cnt_b,
    output logic [CNT_W-1:0]      err_cnt_c
);

    logic                  s1_valid;
    logic [3*DATA_LEN-1:0] s1_data;

    logic                  adv2_c;
    logic                  adv1_c;
    logic                  load2_c;
    logic [DATA_LEN-1:0]   rep_a_c;
    logic [DATA_LEN-1:0]   rep_b_c;
    logic [DATA_LEN-1:0]   rep_c_c;
    logic [DATA_LEN-1:0]   vote_c;
    logic [NUM_REP-1:0]    err_c;
    logic                  multi_c;

    // Stage advance: a stage may load when it is empty or its contents leave this cycle.
    assign adv2_c   = !out_valid || out_ready;
    assign adv1_c   = !s1_valid || adv2_c;
    assign load2_c  = adv2_c && s1_valid;
    assign in_ready = adv1_c;

    assign rep_a_c = s1_data[REP_A*DATA_LEN +: DATA_LEN];
    assign rep_b_c = s1_data[REP_B*DATA_LEN +: DATA_LEN];
    assign rep_c_c = s1_data[REP_C*DATA_LEN +: DATA_LEN];

    // Vote and per-replica disagreement flags for the word sitting in S1.
    always_comb begin
        vote_c = '0;
        err_c  = '0;
        for (int unsigned i = 0; i < DATA_LEN; i++) begin
            vote_c[i] = maj3(rep_a_c[i], rep_b_c[i], rep_c_c[i]);
        end
        err_c[REP_A] = |(rep_a_c ^ vote_c);
        err_c[REP_B] = |(rep_b_c ^ vote_c);
        err_c[REP_C] = |(rep_c_c ^ vote_c);
        // Two or more flags set is exactly a majority of the three flags.
        multi_c = maj3(err_c[0], err_c[1], err_c[2]);
    end

    // S1 valid flag; emptied when the stage advances without a new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (adv1_c) begin
            s1_valid <= in_valid;
        end
    end

    // S1 payload carries no reset; it is only consumed while s1_valid is set.
    always_ff @(posedge clk) begin
        if (in_valid && adv1_c) begin
            s1_data <= in_data;
        end
    end

    // S2 output registers; held while the sink stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= '0;
            out_multi <= 1'b0;
        end else if (adv2_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data  <= vote_c;
                out_err   <= err_c;
                out_multi <= multi_c;
            end
        end
    end

    tmr_err_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (load2_c && err_c[REP_A]),
        .clr   (cnt_clr),
        .cnt   (err_cnt_a)
    );

    tmr_err_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (load2_c && err_c[REP_B]),
        .clr   (cnt_clr),
        .cnt   (err_cnt_b)
    );

    tmr_err_counter #(.CNT_W(CNT_W)) u_cnt_c (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (load2_c && err_c[REP_C]),
        .clr   (cnt_clr),
        .cnt   (err_cnt_c)
    );

endmodule
